// File: rtl/qos_pkg.sv
// Shared types and helpers for the QoS switch: FSM state encoding,
// default FIFO thresholds and the class-field extractor.
package qos_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  // Almost-empty threshold used until INIT programs a new one.
  localparam int unsigned DEF_UMBRAL_LOW = 1;

  // Almost-full threshold used until INIT programs a new one.
  function automatic int unsigned def_umbral_high(input int unsigned depth);
    return depth - 1;
  endfunction

  // Class field lives in the top cw bits of a w-bit word.
  function automatic int unsigned class_of(input logic [31:0] word,
                                           input int unsigned w,
                                           input int unsigned cw);
    logic [31:0] mask;
    mask = (32'd1 << cw) - 32'd1;
    return (word >> (w - cw)) & mask;
  endfunction

endpackage

// File: rtl/qos_if.sv
// Ingress (push/full) and egress (valid/ready) bundle of the QoS switch.
// The switch uses the slave modport; the traffic source/sink uses master.
interface qos_if #(
  parameter int W = 12
);
  logic         push;
  logic [W-1:0] data_in;
  logic         full_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output push, data_in, out_ready,
    input  full_in, out_valid, out_data
  );

  modport slave (
    input  push, data_in, out_ready,
    output full_in, out_valid, out_data
  );
endinterface

// File: rtl/qos_fifo.sv
// Synchronous FIFO with occupancy-based almost-full / almost-empty flags.
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; the head word is presented combinationally so a class can be
// forwarded the cycle after it lands.
module qos_fifo #(
  parameter  int W     = 12,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic [AW-1:0] umbral_high_i,
  input  logic [AW-1:0] umbral_low_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinct.
  assign count          = wr_ptr_q - rd_ptr_q;
  assign full_o         = (count == AW'(DEPTH));
  assign empty_o        = (count == '0);
  assign rd_en          = pop_i & ~empty_o;
  assign wr_en          = push_i & (~full_o | rd_en);
  assign data_o         = mem_q[rd_ptr_q[AW-2:0]];
  assign almost_full_o  = (count >= umbral_high_i);
  assign almost_empty_o = (count <= umbral_low_i);

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-2:0]] <= data_i;
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/qos_switch_param.sv
// QoS switch: one ingress FIFO is split by class into NCH class FIFOs,
// which a round-robin arbiter drains into a registered valid/ready egress.
// Optional feature macro: QOS_WRR_EN adds a weight port and lets the
// arbiter grant a class up to weight[c] consecutive times.
module qos_switch_param
  import qos_pkg::*;
#(
  parameter  int W     = 12,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 8,
  parameter  int CNTW  = 5,
  localparam int CW    = $clog2(NCH),
  localparam int AW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [AW-1:0]   umbral_high,
  input  logic [AW-1:0]   umbral_low,
`ifdef QOS_WRR_EN
  input  logic [NCH*4-1:0] weight,
`endif
  qos_if.slave            bus,
  input  logic            req,
  input  logic [CW-1:0]   idx,
  output logic            cnt_valid,
  output logic [CNTW-1:0] cnt_data,
  output logic [NCH-1:0]  almost_full,
  output logic [NCH-1:0]  almost_empty,
  output logic            active_out,
  output logic            idle_out,
  output logic            error_out
);

  localparam logic [AW-1:0] DEF_LOW  = AW'(DEF_UMBRAL_LOW);
  localparam logic [AW-1:0] DEF_HIGH = AW'(def_umbral_high(DEPTH));

  state_e          state_q, state_d;
  logic [AW-1:0]   umbral_high_q;
  logic [AW-1:0]   umbral_low_q;

  logic [W-1:0]    ing_data;
  logic            ing_full;
  logic            ing_empty;
  logic            ing_pop;
  logic [CW-1:0]   ing_class;
  logic            ing_af_unused;
  logic            ing_ae_unused;

  logic [NCH-1:0]  cls_push;
  logic [NCH-1:0]  cls_pop;
  logic [NCH-1:0]  cls_full;
  logic [NCH-1:0]  cls_empty;
  logic [W-1:0]    cls_head [NCH];

  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [CW-1:0]   out_class;
  logic            egress_free;
  logic            egress_fire;

  logic [CW-1:0]   last_q;
  logic            grant_valid;
  logic [CW-1:0]   grant_idx;

  logic [CNTW-1:0] cnt_q [NCH];
  logic            cnt_valid_q;
  logic [CNTW-1:0] cnt_data_q;
  logic            error_q;
  logic            busy;

`ifdef QOS_WRR_EN
  logic [3:0]      weight_q [NCH];
  logic [4:0]      burst_q;
  logic [4:0]      eff_weight;

  // A programmed weight of zero still earns one grant per turn.
  assign eff_weight = (weight_q[last_q] == 4'd0) ? 5'd1 : {1'b0, weight_q[last_q]};
`endif

  // ---------------------------------------------------------------- ingress
  qos_fifo #(.W(W), .DEPTH(DEPTH)) u_ing_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (bus.push),
    .data_i         (bus.data_in),
    .pop_i          (ing_pop),
    .umbral_high_i  (umbral_high_q),
    .umbral_low_i   (umbral_low_q),
    .data_o         (ing_data),
    .full_o         (ing_full),
    .empty_o        (ing_empty),
    .almost_full_o  (ing_af_unused),
    .almost_empty_o (ing_ae_unused)
  );

  assign ing_class   = CW'(class_of(32'(ing_data), W, CW));
  // Head-of-line: the head only moves when its own class has room.
  assign ing_pop     = ~ing_empty & ~cls_full[ing_class];
  assign bus.full_in = ing_full;

  // ----------------------------------------------------------- class FIFOs
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cls
      assign cls_push[gi] = ing_pop & (ing_class == CW'(gi));
      assign cls_pop[gi]  = grant_valid & (grant_idx == CW'(gi));

      qos_fifo #(.W(W), .DEPTH(DEPTH)) u_cls_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (cls_push[gi]),
        .data_i         (ing_data),
        .pop_i          (cls_pop[gi]),
        .umbral_high_i  (umbral_high_q),
        .umbral_low_i   (umbral_low_q),
        .data_o         (cls_head[gi]),
        .full_o         (cls_full[gi]),
        .empty_o        (cls_empty[gi]),
        .almost_full_o  (almost_full[gi]),
        .almost_empty_o (almost_empty[gi])
      );
    end
  endgenerate

  // --------------------------------------------------------------- arbiter
  assign egress_free = ~out_valid_q | bus.out_ready;
  assign egress_fire = out_valid_q & bus.out_ready;

  // Pick the first non-empty class after the last grant; i == NCH wraps
  // back onto the last granted class itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_q;
    if (egress_free) begin
      for (int i = 1; i <= NCH; i++) begin
        if (!grant_valid && !cls_empty[last_q + CW'(i)]) begin
          grant_valid = 1'b1;
          grant_idx   = last_q + CW'(i);
        end
      end
`ifdef QOS_WRR_EN
      if (!cls_empty[last_q] && (burst_q < eff_weight)) begin
        grant_valid = 1'b1;
        grant_idx   = last_q;
      end
`endif
    end
  end

  // Remember the granted class so the next search starts after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= CW'(NCH - 1);
    end else if (grant_valid) begin
      last_q <= grant_idx;
    end
  end

`ifdef QOS_WRR_EN
  // Count consecutive grants to the same class; saturates so it never
  // wraps back below a weight.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q <= '1;
    end else if (grant_valid) begin
      if (grant_idx != last_q) begin
        burst_q <= 5'd1;
      end else if (burst_q != '1) begin
        burst_q <= burst_q + 5'd1;
      end
    end
  end

  // Weights are programmed alongside the thresholds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) weight_q[c] <= 4'd0;
    end else if (state_q == ST_INIT && init) begin
      for (int c = 0; c < NCH; c++) weight_q[c] <= weight[c*4 +: 4];
    end
  end
`endif

  // ---------------------------------------------------------------- egress
  // Egress register: load on grant, clear once accepted, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (grant_valid) begin
      out_valid_q <= 1'b1;
      out_data_q  <= cls_head[grant_idx];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign out_class     = CW'(class_of(32'(out_data_q), W, CW));

  // -------------------------------------------------------------- counters
  // Per-class delivery counters, wrapping naturally at 2^CNTW.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else if (egress_fire) begin
      cnt_q[out_class] <= cnt_q[out_class] + CNTW'(1);
    end
  end

  // Counter read port: answered only while the switch is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_valid_q <= 1'b0;
      cnt_data_q  <= '0;
    end else begin
      cnt_valid_q <= (state_q == ST_IDLE) & req;
      if ((state_q == ST_IDLE) && req) begin
        cnt_data_q <= cnt_q[idx];
      end
    end
  end

  assign cnt_valid = cnt_valid_q;
  assign cnt_data  = cnt_data_q;

  // ----------------------------------------------------------- error flag
  // Sticky: a push that finds the ingress full without a same-cycle drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (bus.push && ing_full && !ing_pop) begin
      error_q <= 1'b1;
    end
  end

  assign error_out = error_q;

  // ------------------------------------------------------------------- FSM
  assign busy = ~ing_empty | (cls_empty != '1) | out_valid_q;

  // State register plus threshold latch while INIT is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RESET;
      umbral_high_q <= DEF_HIGH;
      umbral_low_q  <= DEF_LOW;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT && init) begin
        umbral_high_q <= umbral_high;
        umbral_low_q  <= umbral_low;
      end
    end
  end

  // Next-state logic; INIT can be re-entered at any time without flushing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)      state_d = ST_INIT;
        else if (busy) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)       state_d = ST_INIT;
        else if (!busy) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);

endmodule
